// File: rtl/dvp_tx_pkg.sv
// Shared definitions for the DVP test-pattern transmitter:
// FSM state encoding, pattern_sel codes and the colour-bar palette.
package dvp_tx_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBP    = 3'd2,
    ACTIVE = 3'd3,
    VFP    = 3'd4
  } dvp_state_e;

  // pattern_sel codes.
  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_GREY  = 2'd1;
  localparam logic [1:0] PAT_SOLID = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  // Colour-bar palette in RGB565, left to right.
  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  // Palette lookup by bar index (0 = leftmost).
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Pixel generator for the DVP transmitter. Maps (x, y, sel, solid) to an
// RGB565 pixel combinationally. The only state is the colour-bar
// sub-counter, which tracks the bar index without a divider: it restarts on
// pix_first (x = 0) and advances on pix_step (x increments).
module dvp_pattern_gen #(
  parameter int H_ACTIVE = 640
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_first,
  input  logic        pix_step,
  input  logic [1:0]  sel,
  input  logic [15:0] solid,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] pixel
);
  import dvp_tx_pkg::*;

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int SUB_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BAR_W - 1);

  logic [SUB_W-1:0] sub_reg, sub_next;
  logic [2:0]       bar_reg, bar_next;
  logic             unused_bits;

  // Bar tracking: the sub-counter wraps every BAR_W pixels and each wrap
  // moves to the next bar; the bar index sticks at the last bar through
  // the blanking interval until the next line restarts it.
  always_comb begin
    sub_next = sub_reg;
    bar_next = bar_reg;
    if (pix_first) begin
      sub_next = '0;
      bar_next = 3'd0;
    end else if (pix_step) begin
      if (sub_reg == SUB_LAST) begin
        sub_next = '0;
        if (bar_reg != 3'd7) begin
          bar_next = bar_reg + 3'd1;
        end
      end else begin
        sub_next = sub_reg + 1'b1;
      end
    end
  end

  // Bar sub-counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_reg <= '0;
      bar_reg <= 3'd0;
    end else begin
      sub_reg <= sub_next;
      bar_reg <= bar_next;
    end
  end

  // Pattern select: the bar colour uses the updated index so it lines up
  // with the x presented on this cycle.
  always_comb begin
    pixel = 16'h0000;
    case (sel)
      PAT_BARS:  pixel = bar_colour(bar_next);
      PAT_GREY:  pixel = {x[7:3], x[7:2], x[7:3]};
      PAT_SOLID: pixel = solid;
      PAT_CHECK: pixel = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
      default:   pixel = 16'h0000;
    endcase
  end

  // Only some coordinate bits feed the patterns.
  assign unused_bits = ^{x[1:0], y[7:4], y[2:0]};

endmodule

// File: rtl/dvp_pattern_tx.sv
// DVP camera-side test-pattern transmitter. Generates RGB565 frames as a
// high-byte-first byte stream with sensor-style vsync/href timing, one byte
// per clk_24m cycle.
// Optional build macro DVP_FRAME_CNT_EN: adds a 16-bit frame_cnt output and
// stamps its value into pixel (0,0) of every frame.
// All outputs are registered from the next-state values, so the output
// registers always describe the byte slot held in state_reg/bx_reg/ly_reg.
module dvp_pattern_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        clk_24m,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb565,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_done,
  output logic        busy
`ifdef DVP_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);
  import dvp_tx_pkg::*;

  localparam int L        = 2 * H_ACTIVE + H_BLANK;
  localparam int BX_W     = $clog2(L);
  localparam int HREF_END = 2 * H_ACTIVE;

  localparam int LM_A     = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
  localparam int LM_B     = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
  localparam int LINE_MAX = (LM_A > LM_B) ? LM_A : LM_B;
  localparam int LY_W     = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  localparam logic [BX_W-1:0] BX_LAST  = BX_W'(L - 1);
  localparam logic [BX_W-1:0] BX_HREND = BX_W'(HREF_END);
  localparam logic [LY_W-1:0] VS_LAST  = LY_W'(VSYNC_LINES - 1);
  localparam logic [LY_W-1:0] VBP_LAST = LY_W'(VBP_LINES - 1);
  localparam logic [LY_W-1:0] ACT_LAST = LY_W'(V_ACTIVE - 1);
  localparam logic [LY_W-1:0] VFP_LAST = LY_W'(VFP_LINES - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_VSYNC  = VSYNC;
  localparam logic [2:0] S_VBP    = VBP;
  localparam logic [2:0] S_ACTIVE = ACTIVE;
  localparam logic [2:0] S_VFP    = VFP;

  logic [2:0]      state_reg, state_next;
  logic [BX_W-1:0] bx_reg, bx_next;
  logic [LY_W-1:0] ly_reg, ly_next;
  logic            line_end;
  logic            last_line;
  logic            latch;

  logic [1:0]      sel_reg;
  logic [15:0]     solid_reg;

  logic [BX_W+7:0] x_ext;
  logic [LY_W+7:0] y_ext;
  logic            pix_first;
  logic            pix_step;
  logic [15:0]     gen_pixel;
  logic [15:0]     pix;

  logic            vsync_next;
  logic            href_next;
  logic [7:0]      data_next;
  logic            fd_next;
  logic            busy_next;
  logic            unused_bits;

`ifdef DVP_FRAME_CNT_EN
  logic [15:0]     cnt_reg;
`endif

  assign line_end = (bx_reg == BX_LAST);

  // Whether the current line is the last one of the current state.
  always_comb begin
    last_line = 1'b0;
    case (state_reg)
      S_VSYNC:  last_line = (ly_reg == VS_LAST);
      S_VBP:    last_line = (ly_reg == VBP_LAST);
      S_ACTIVE: last_line = (ly_reg == ACT_LAST);
      S_VFP:    last_line = (ly_reg == VFP_LAST);
      default:  last_line = 1'b0;
    endcase
  end

  // Sequencer: byte counter within a line, line counter within a state,
  // state advance at the end of each state's last line. The pattern and
  // colour are captured only when a new frame begins.
  always_comb begin
    state_next = state_reg;
    bx_next    = bx_reg;
    ly_next    = ly_reg;
    latch      = 1'b0;
    if (state_reg == S_IDLE) begin
      bx_next = '0;
      ly_next = '0;
      if (tx_en) begin
        state_next = S_VSYNC;
        latch      = 1'b1;
      end
    end else if (!line_end) begin
      bx_next = bx_reg + 1'b1;
    end else begin
      bx_next = '0;
      if (!last_line) begin
        ly_next = ly_reg + 1'b1;
      end else begin
        ly_next = '0;
        case (state_reg)
          S_VSYNC:  state_next = S_VBP;
          S_VBP:    state_next = S_ACTIVE;
          S_ACTIVE: state_next = S_VFP;
          S_VFP: begin
            if (tx_en) begin
              state_next = S_VSYNC;
              latch      = 1'b1;
            end else begin
              state_next = S_IDLE;
            end
          end
          default:  state_next = S_IDLE;
        endcase
      end
    end
  end

  // Sequencer state and latched frame settings.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      bx_reg    <= '0;
      ly_reg    <= '0;
      sel_reg   <= PAT_BARS;
      solid_reg <= 16'h0000;
    end else begin
      state_reg <= state_next;
      bx_reg    <= bx_next;
      ly_reg    <= ly_next;
      if (latch) begin
        sel_reg   <= pattern_sel;
        solid_reg <= solid_rgb565;
      end
    end
  end

  // Pixel coordinates of the upcoming byte slot: x = bx >> 1, y = line.
  assign x_ext     = {8'd0, bx_next} >> 1;
  assign y_ext     = {8'd0, ly_next};
  assign pix_first = (bx_next == '0);
  assign pix_step  = !bx_next[0] && (bx_next != '0);

  dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_gen (
    .clk       (clk_24m),
    .rst_n     (rst_n),
    .pix_first (pix_first),
    .pix_step  (pix_step),
    .sel       (sel_reg),
    .solid     (solid_reg),
    .x         (x_ext[7:0]),
    .y         (y_ext[7:0]),
    .pixel     (gen_pixel)
  );

`ifdef DVP_FRAME_CNT_EN
  // Pixel (0,0) carries the frame counter so the receiver can spot drops.
  always_comb begin
    pix = gen_pixel;
    if ((bx_next < BX_W'(2)) && (ly_next == '0)) begin
      pix = cnt_reg;
    end
  end
`else
  assign pix = gen_pixel;
`endif

  // Output values for the upcoming slot: high byte on even bx, low byte on
  // odd bx, data forced to zero outside href.
  always_comb begin
    vsync_next = (state_next == S_VSYNC);
    href_next  = (state_next == S_ACTIVE) && (bx_next < BX_HREND);
    data_next  = 8'd0;
    if (href_next) begin
      data_next = bx_next[0] ? pix[7:0] : pix[15:8];
    end
    fd_next    = (state_next == S_VFP) && (bx_next == BX_LAST) &&
                 (ly_next == VFP_LAST);
    busy_next  = (state_next != S_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      dvp_vsync  <= 1'b0;
      dvp_href   <= 1'b0;
      dvp_data   <= 8'd0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dvp_vsync  <= vsync_next;
      dvp_href   <= href_next;
      dvp_data   <= data_next;
      frame_done <= fd_next;
      busy       <= busy_next;
    end
  end

`ifdef DVP_FRAME_CNT_EN
  // Completed-frame counter, wrapping at 16 bits.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 16'h0000;
    end else if (fd_next) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign frame_cnt = cnt_reg;
`endif

  // Coordinate bits above the pattern generator's reach.
  assign unused_bits = ^{x_ext[BX_W+7:8], y_ext[LY_W+7:8]};

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Self-checking bench for dvp_pattern_tx. A small-geometry instance checks
// frame timing, byte order and the patterns (every active byte is compared
// against a scoreboard filled from a reference pixel model when each frame
// is started); a second instance with a taller/wider frame checks the
// checkerboard. Build with DVP_FRAME_CNT_EN to also cover the frame counter.
module tb_dvp_pattern_tx;

  localparam int H  = 16;
  localparam int HB = 4;
  localparam int V  = 4;
  localparam int L  = 2 * H + HB;
  localparam int FRAME = (1 + 1 + V + 1) * L;

  localparam int H2 = 32;
  localparam int V2 = 16;
  localparam int L2 = 2 * H2 + HB;
  localparam int FRAME2 = (1 + 1 + V2 + 1) * L2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en = 1'b0;
  logic        tx_en_b = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb565 = 16'h0000;

  logic        vsync, href, frame_done, busy;
  logic [7:0]  data;
  logic        vsync_b, href_b, frame_done_b, busy_b;
  logic [7:0]  data_b;
`ifdef DVP_FRAME_CNT_EN
  logic [15:0] frame_cnt, frame_cnt_b;
`endif

  always #5 clk = ~clk;

  dvp_pattern_tx #(
    .H_ACTIVE(H), .H_BLANK(HB), .V_ACTIVE(V),
    .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
  ) dut (
    .clk_24m      (clk),
    .rst_n        (rst_n),
    .tx_en        (tx_en),
    .pattern_sel  (pattern_sel),
    .solid_rgb565 (solid_rgb565),
    .dvp_vsync    (vsync),
    .dvp_href     (href),
    .dvp_data     (data),
    .frame_done   (frame_done),
    .busy         (busy)
`ifdef DVP_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  dvp_pattern_tx #(
    .H_ACTIVE(H2), .H_BLANK(HB), .V_ACTIVE(V2),
    .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
  ) dut_ck (
    .clk_24m      (clk),
    .rst_n        (rst_n),
    .tx_en        (tx_en_b),
    .pattern_sel  (2'd3),
    .solid_rgb565 (16'h0000),
    .dvp_vsync    (vsync_b),
    .dvp_href     (href_b),
    .dvp_data     (data_b),
    .frame_done   (frame_done_b),
    .busy         (busy_b)
`ifdef DVP_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt_b)
`endif
  );

  int total = 0;
  int bad   = 0;
  int fcount = 0;
  logic [7:0] exp_q[$];
  logic [7:0] line0 [2*H];

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] solid;
    logic        mid_chg;
    logic [1:0]  mid_sel;
    logic        drop;
    logic [15:0] px8;
    logic [15:0] px15;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pixel for the small instance (bars via division).
  function automatic logic [15:0] model_px(input logic [1:0] sel, input logic [15:0] solid,
                                           input int x, input int y);
    logic [15:0] xb, yb, p;
    xb = 16'(x);
    yb = 16'(y);
    p  = 16'h0000;
    case (sel)
      2'd0: begin
        case (x / (H / 8))
          0: p = 16'hFFFF;
          1: p = 16'hFFE0;
          2: p = 16'h07FF;
          3: p = 16'h07E0;
          4: p = 16'hF81F;
          5: p = 16'hF800;
          6: p = 16'h001F;
          default: p = 16'h0000;
        endcase
      end
      2'd1: p = {xb[7:3], xb[7:2], xb[7:3]};
      2'd2: p = solid;
      default: p = (xb[3] ^ yb[3]) ? 16'hFFFF : 16'h0000;
    endcase
    return p;
  endfunction

  // Queue every active byte of one frame, high byte first.
  task automatic push_frame(input logic [1:0] sel, input logic [15:0] solid);
    logic [15:0] p;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        p = model_px(sel, solid, x, y);
`ifdef DVP_FRAME_CNT_EN
        if (x == 0 && y == 0) p = 16'(fcount);
`endif
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
    end
  endtask

  // Scoreboard monitor: every href byte is popped and compared; blanking
  // bytes must be zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (href) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got byte %0h expected none (t=%0t)", data, $time);
        end else begin
          chk("sb_byte", 32'(data), 32'(exp_q.pop_front()));
        end
      end else begin
        chk("blank_data", 32'(data), 32'd0);
      end
    end
  end

  // Walk one frame from its first slot; returns timing measurements.
  task automatic run_frame(input logic drop, input logic mid_chg, input logic [1:0] mid_sel,
                           output int vs_cnt, output int vs_first, output int href_first,
                           output int href_cnt, output int lines, output int fd_cyc);
    logic prev_href;
    int   bi;
    prev_href = 1'b0;
    bi = 0;
    vs_cnt = 0; vs_first = 0; href_first = 0; href_cnt = 0; lines = 0; fd_cyc = 0;
    for (int c = 1; c <= FRAME + 100; c++) begin
      @(negedge clk);
      if (vsync) begin
        vs_cnt++;
        if (vs_first == 0) vs_first = c;
      end
      if (href) begin
        href_cnt++;
        if (href_first == 0) href_first = c;
        if (!prev_href) begin
          lines++;
          bi = 0;
        end
        if (lines == 1 && bi < 2 * H) line0[bi] = data;
        bi++;
      end
      prev_href = href;
      if (drop && c == 115) tx_en = 1'b0;
      if (mid_chg && c == 100) pattern_sel = mid_sel;
      if (frame_done) begin
        fd_cyc = c;
        fcount++;
        break;
      end
    end
  endtask

  task automatic frame_and_check(input string tag, input vec_t v);
    int vs_cnt, vs_first, href_first, href_cnt, lines, fd_cyc;
    pattern_sel  = v.sel;
    solid_rgb565 = v.solid;
    tx_en        = 1'b1;
    push_frame(v.sel, v.solid);
    run_frame(v.drop, v.mid_chg, v.mid_sel, vs_cnt, vs_first, href_first, href_cnt, lines, fd_cyc);
    $display("frame %s sel=%0d solid=%h vs=%0d href=%0d lines=%0d done@%0d",
             tag, v.sel, v.solid, vs_cnt, href_cnt, lines, fd_cyc);
    chk({tag, "_vs_first"},   32'(vs_first),   32'd1);
    chk({tag, "_vs_cnt"},     32'(vs_cnt),     32'(L));
    chk({tag, "_href_first"}, 32'(href_first), 32'(2 * L + 1));
    chk({tag, "_href_cnt"},   32'(href_cnt),   32'(2 * H * V));
    chk({tag, "_lines"},      32'(lines),      32'(V));
    chk({tag, "_done_cyc"},   32'(fd_cyc),     32'(FRAME));
    chk({tag, "_px8"},  32'({line0[16], line0[17]}), 32'(v.px8));
    chk({tag, "_px15"}, 32'({line0[30], line0[31]}), 32'(v.px15));
`ifdef DVP_FRAME_CNT_EN
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(fcount));
`endif
  endtask

  initial begin
    int vs_idle;
    int lb, bi, fdc;
    logic prev;
    logic [15:0] p80, p88, p08;

    vecs[0] = '{sel:2'd2, solid:16'hA5C3, mid_chg:1'b0, mid_sel:2'd0, drop:1'b0, px8:16'hA5C3, px15:16'hA5C3};
    vecs[1] = '{sel:2'd2, solid:16'hA5C3, mid_chg:1'b1, mid_sel:2'd0, drop:1'b0, px8:16'hA5C3, px15:16'hA5C3};
    vecs[2] = '{sel:2'd0, solid:16'hA5C3, mid_chg:1'b0, mid_sel:2'd0, drop:1'b0, px8:16'hF81F, px15:16'h0000};
    vecs[3] = '{sel:2'd1, solid:16'h0000, mid_chg:1'b0, mid_sel:2'd0, drop:1'b0, px8:16'h0841, px15:16'h0861};
    vecs[4] = '{sel:2'd3, solid:16'h1234, mid_chg:1'b0, mid_sel:2'd0, drop:1'b0, px8:16'hFFFF, px15:16'hFFFF};
    vecs[5] = '{sel:2'd2, solid:16'h0F0F, mid_chg:1'b0, mid_sel:2'd0, drop:1'b1, px8:16'h0F0F, px15:16'h0F0F};

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vsync", 32'(vsync), 32'd0);
    chk("rst_href",  32'(href),  32'd0);
    chk("rst_data",  32'(data),  32'd0);
    chk("rst_done",  32'(frame_done), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
`ifdef DVP_FRAME_CNT_EN
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy",  32'(busy),  32'd0);
    chk("idle_vsync", 32'(vsync), 32'd0);

    // Table of back-to-back frames; the last one drops tx_en mid-frame.
    for (int i = 0; i < 6; i++) begin
      frame_and_check($sformatf("v%0d", i), vecs[i]);
      if (vecs[i].drop) begin
        @(negedge clk);
        chk("drop_busy",  32'(busy),  32'd0);
        chk("drop_vsync", 32'(vsync), 32'd0);
        vs_idle = 0;
        repeat (40) begin
          @(negedge clk);
          if (vsync || busy) vs_idle++;
        end
        chk("drop_stays_idle", 32'(vs_idle), 32'd0);
      end
    end

    // Reset in the middle of an active line.
    pattern_sel  = 2'd2;
    solid_rgb565 = 16'h3C5A;
    tx_en        = 1'b1;
    push_frame(2'd2, 16'h3C5A);
    repeat (2 * L + 8) @(negedge clk);
    chk("pre_rst_href", 32'(href), 32'd1);
    chk("pre_rst_data", 32'(data), 32'h5A);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-line: vsync=%0b href=%0b data=%h busy=%0b", vsync, href, data, busy);
    chk("arst_vsync", 32'(vsync), 32'd0);
    chk("arst_href",  32'(href),  32'd0);
    chk("arst_data",  32'(data),  32'd0);
    chk("arst_busy",  32'(busy),  32'd0);
    chk("arst_done",  32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    fcount = 0;
`ifdef DVP_FRAME_CNT_EN
    chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    frame_and_check("after_rst1", '{sel:2'd2, solid:16'h3C5A, mid_chg:1'b0, mid_sel:2'd0,
                                    drop:1'b0, px8:16'h3C5A, px15:16'h3C5A});
    frame_and_check("after_rst2", '{sel:2'd2, solid:16'h3C5A, mid_chg:1'b0, mid_sel:2'd0,
                                    drop:1'b0, px8:16'h3C5A, px15:16'h3C5A});
    tx_en = 1'b0;
    @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    // Checkerboard on the larger instance.
    lb = 0; bi = 0; fdc = 0; prev = 1'b0;
    p80 = 16'hxxxx; p88 = 16'hxxxx; p08 = 16'hxxxx;
    tx_en_b = 1'b1;
    for (int c = 1; c <= FRAME2 + 100; c++) begin
      @(negedge clk);
      if (c == 2) tx_en_b = 1'b0;
      if (href_b) begin
        if (!prev) begin
          lb++;
          bi = 0;
        end
        if (lb == 1 && bi == 16) p80[15:8] = data_b;
        if (lb == 1 && bi == 17) p80[7:0]  = data_b;
        if (lb == 9 && bi == 16) p88[15:8] = data_b;
        if (lb == 9 && bi == 17) p88[7:0]  = data_b;
        if (lb == 9 && bi == 0)  p08[15:8] = data_b;
        if (lb == 9 && bi == 1)  p08[7:0]  = data_b;
        bi++;
      end
      prev = href_b;
      if (frame_done_b) begin
        fdc = c;
        break;
      end
    end
    $display("checker frame: lines=%0d (8,0)=%h (8,8)=%h (0,8)=%h done@%0d", lb, p80, p88, p08, fdc);
    chk("ck_lines",  32'(lb),  32'(V2));
    chk("ck_px_8_0", 32'(p80), 32'hFFFF);
    chk("ck_px_8_8", 32'(p88), 32'h0000);
    chk("ck_px_0_8", 32'(p08), 32'hFFFF);
    chk("ck_done",   32'(fdc), 32'(FRAME2));
    @(negedge clk);
    chk("ck_idle_busy", 32'(busy_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
